seg_scan_ctrl: RTL and testbench

//  Time-multiplexes one hex_to_7seg decoder across N_DIG common-anode digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_hex_to_7seg.sv | 50 +++++
 rtl/seg_scan_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   SEG_BLANK   - active-low segment pattern with every segment off
//   SEG_E       - active-low pattern for the letter 'E' (error display)
//   DIG_W       - bits per displayed hex digit
//   scanState_e - per-slot FSM states (ST_DEAD anti-ghost gap, ST_ON lit)
// -----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7f;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam int         DIG_W     = 4;

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } scanState_e;

endpackage

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_hex_to_7seg
// Combinational hex to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
// Ports:
//   hex_i    in  DIG_W  nibble to display
//   blank_i  in  1      force all segments off (highest priority)
//   error_i  in  1      show 'E' instead of the nibble
//   seg_o    out 7      active-low segment drive
// -----------------------------------------------------------------------------
module seg_scan_ctrl_hex_to_7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [DIG_W-1:0] hex_i,
  input  logic             blank_i,
  input  logic             error_i,
  output logic [6:0]       seg_o
);

  // Blank wins over error, error wins over the hex glyph. Glyph table uses
  // lower-case b and d so they are distinguishable from 8 and 0.
  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (error_i) begin
      seg_o = SEG_E;
    end else begin
      case (hex_i)
        4'h0:    seg_o = 7'h40;
        4'h1:    seg_o = 7'h79;
        4'h2:    seg_o = 7'h24;
        4'h3:    seg_o = 7'h30;
        4'h4:    seg_o = 7'h19;
        4'h5:    seg_o = 7'h12;
        4'h6:    seg_o = 7'h02;
        4'h7:    seg_o = 7'h78;
        4'h8:    seg_o = 7'h00;
        4'h9:    seg_o = 7'h10;
        4'hA:    seg_o = 7'h08;
        4'hB:    seg_o = 7'h03;
        4'hC:    seg_o = 7'h46;
        4'hD:    seg_o = 7'h21;
        4'hE:    seg_o = 7'h06;
        4'hF:    seg_o = 7'h0e;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes one hex-to-7-segment decoder across N_DIG common-anode
// digits. Holds a frame-synchronous display register fed from the datapath and
// applies leading-zero blanking, error display and anti-ghost dead time.
// Optional feature macro: SEG_SCAN_BLINK_EN (per-digit blinking via blink_mask).
// Ports:
//   clk         in   1            system clock
//   rst_n       in   1            asynchronous active-low reset
//   value_i     in   4*N_DIG      hex value, nibble k -> digit k
//   load        in   1            capture value_i into the pending register
//   load_ack    out  1            pulse when a new value enters the display
//   error       in   1            show 'E' on every lit digit
//   blank       in   1            all segments off, overrides error
//   lzb_en      in   1            leading-zero blanking enable
//   blink_mask  in   N_DIG        digits to blink (blink build only)
//   frame_tick  out  1            last cycle of slot N_DIG-1
//   an          out  N_DIG        active-low anode enables
//   seg         out  7            active-low segments
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIG        = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIG_W*N_DIG-1:0] value_i,
  input  logic                   load,
  output logic                   load_ack,
  input  logic                   error,
  input  logic                   blank,
  input  logic                   lzb_en,
  input  logic [N_DIG-1:0]       blink_mask,
  output logic                   frame_tick,
  output logic [N_DIG-1:0]       an,
  output logic [6:0]             seg
);

  localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int               IDX_W     = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int               VAL_W     = DIG_W * N_DIG;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scanState_e       state_q, state_d;
  logic [VAL_W-1:0] pend_q, pend_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  logic             pendVld_q, pendVld_d;
  logic             loadAck_q, loadAck_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [DIG_W-1:0] hexDig_q, hexDig_d;
  logic             segBlank_q, segBlank_d;
  logic             segErr_q, segErr_d;
  logic             slotEnd;
  logic             frameEnd;
  logic [N_DIG-1:0] lzMask;
  logic             lzbOff;
  logic             blinkOff;

  assign slotEnd  = (cnt_q == CNT_LAST);
  assign frameEnd = slotEnd && (idx_q == IDX_LAST);

  // Slot timing: cnt sweeps one digit slot, idx picks the digit and wraps
  // modulo N_DIG so non-power-of-two digit counts scan correctly.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slotEnd) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Per-slot FSM. The state always describes the current cnt value: it leaves
  // DEAD as cnt steps onto DEAD_CYC and returns to DEAD as the slot wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DEAD: if (cnt_q == DEAD_LAST) state_d = ST_ON;
      ST_ON:   if (slotEnd)            state_d = ST_DEAD;
      default: state_d = ST_DEAD;
    endcase
  end

  // Pending/display handoff. A mid-frame load parks in pending (last write
  // wins); at the frame boundary a same-cycle load bypasses pending so the
  // value shows in the very next frame. Acknowledge only real updates.
  always_comb begin
    pend_d    = pend_q;
    pendVld_d = pendVld_q;
    disp_d    = disp_q;
    loadAck_d = 1'b0;
    if (load) begin
      pend_d    = value_i;
      pendVld_d = 1'b1;
    end
    if (frameEnd) begin
      if (load) begin
        disp_d    = value_i;
        pendVld_d = 1'b0;
        loadAck_d = 1'b1;
      end else if (pendVld_q) begin
        disp_d    = pend_q;
        pendVld_d = 1'b0;
        loadAck_d = 1'b1;
      end
    end
  end

  // Leading-zero map: bit k is set when nibbles k..N_DIG-1 are all zero.
  // Built top-down so each bit folds in the nibbles above it.
  always_comb begin
    logic allZero;
    allZero = 1'b1;
    lzMask  = '0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      allZero   = allZero & (disp_q[k*DIG_W +: DIG_W] == '0);
      lzMask[k] = allZero;
    end
  end

  assign lzbOff = lzb_en && (idx_q != '0) && lzMask[idx_q];

`ifdef SEG_SCAN_BLINK_EN
  localparam int               FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [FRM_W-1:0] frmCnt_q, frmCnt_d;
  logic             phase_q, phase_d;

  // Blink phase flips after every BLINK_FRAMES frame boundaries, so a
  // masked digit stays dark and lit for whole frames at a time.
  always_comb begin
    frmCnt_d = frmCnt_q;
    phase_d  = phase_q;
    if (frameEnd) begin
      if (frmCnt_q == FRM_LAST) begin
        frmCnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        frmCnt_d = frmCnt_q + FRM_W'(1);
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frmCnt_q <= '0;
      phase_q  <= 1'b0;
    end else begin
      frmCnt_q <= frmCnt_d;
      phase_q  <= phase_d;
    end
  end

  assign blinkOff = phase_q & blink_mask[idx_q];
`else
  logic unusedBlink;
  assign unusedBlink = ^{blink_mask, BLINK_FRAMES[0]};
  assign blinkOff    = 1'b0;
`endif

  // Pin-side values for the next cycle. Anodes and decoder inputs are
  // registered together so seg and an always switch on the same edge.
  // During the dead time every anode is off and the decoder is blanked.
  always_comb begin
    an_d       = '1;
    segBlank_d = 1'b1;
    segErr_d   = error;
    hexDig_d   = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_q == IDX_W'(k)) hexDig_d = disp_q[k*DIG_W +: DIG_W];
    end
    if (state_q == ST_ON) begin
      an_d[idx_q] = 1'b0;
      segBlank_d  = blank | (~error & (blinkOff | lzbOff));
    end
  end

  // All scan, handoff and pin registers share one asynchronous reset so the
  // display goes dark the instant rst_n falls and restarts at digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      state_q    <= ST_DEAD;
      pend_q     <= '0;
      pendVld_q  <= 1'b0;
      disp_q     <= '0;
      loadAck_q  <= 1'b0;
      an_q       <= '1;
      hexDig_q   <= '0;
      segBlank_q <= 1'b1;
      segErr_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      pendVld_q  <= pendVld_d;
      disp_q     <= disp_d;
      loadAck_q  <= loadAck_d;
      an_q       <= an_d;
      hexDig_q   <= hexDig_d;
      segBlank_q <= segBlank_d;
      segErr_q   <= segErr_d;
    end
  end

  seg_scan_ctrl_hex_to_7seg u_hex_to_7seg (
    .hex_i   (hexDig_q),
    .blank_i (segBlank_q),
    .error_i (segErr_q),
    .seg_o   (seg)
  );

  assign an         = an_q;
  assign load_ack   = loadAck_q;
  assign frame_tick = frameEnd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with N_DIG=4, REFRESH_DIV=4,
// DEAD_CYC=1, BLINK_FRAMES=2. Expected per-digit an/seg pairs are queued when
// a frame's stimulus is set up and popped as the DUT scans each digit.
// Blink expectations follow SEG_SCAN_BLINK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int N_DIG        = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int DEAD_CYC     = 1;
  localparam int BLINK_FRAMES = 2;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value_i;
  logic        load;
  logic        load_ack;
  logic        error;
  logic        blank;
  logic        lzb_en;
  logic [3:0]  blink_mask;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slotExp_t;

  slotExp_t sbQueue[$];
  int       assertCount = 0;
  int       failCount = 0;

  seg_scan_ctrl #(
    .N_DIG        (N_DIG),
    .REFRESH_DIV  (REFRESH_DIV),
    .DEAD_CYC     (DEAD_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (value_i),
    .load       (load),
    .load_ack   (load_ack),
    .error      (error),
    .blank      (blank),
    .lzb_en     (lzb_en),
    .blink_mask (blink_mask),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg)
  );

  // 10-unit clock; all sampling and driving happens on the falling edge.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference glyphs, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] refSeg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0e;
    endcase
    return s;
  endfunction

  // Queue the four digit expectations for one frame of the given display.
  task automatic pushFrame(input logic [15:0] val, input logic lzb, input logic err,
                           input logic blk, input logic [3:0] dark);
    slotExp_t e;
    for (int k = 0; k < N_DIG; k++) begin
      logic [3:0] nib;
      logic       above;
      nib   = val[k*4 +: 4];
      above = ((val >> (k * 4)) == 16'h0);
      e.an    = 4'hf;
      e.an[k] = 1'b0;
      if (blk)                          e.seg = 7'h7f;
      else if (err)                     e.seg = 7'h06;
      else if (dark[k])                 e.seg = 7'h7f;
      else if (lzb && k > 0 && above)   e.seg = 7'h7f;
      else                              e.seg = refSeg(nib);
      sbQueue.push_back(e);
    end
  endtask

  // One load pulse, driven at the falling edge for a single clock.
  task automatic applyStimulus(input logic [15:0] val);
    @(negedge clk);
    value_i = val;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Wait for frame_tick, bounded; n = falling edges waited, 0 on timeout.
  task automatic waitFrameTick(output int n);
    n = 0;
    for (int i = 1; i <= 64 && n == 0; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) n = i;
    end
    if (n == 0) checkOutput("frameTickTimeout", 0, 1);
  endtask

  // Called on the falling edge of a frame_tick cycle. Walks the following
  // 16 cycles: pins trail the counters by one clock, so slot k shows its dead
  // cycle at j = 2+4k and its lit cycles at j = 3+4k .. 5+4k.
  task automatic scanFrame(input string tag, input logic ackExp);
    slotExp_t e;
    e = '0;
    for (int j = 1; j <= 16; j++) begin
      int k;
      int pos;
      @(negedge clk);
      if (j == 1) begin
        checkOutput({tag, "/ack"}, load_ack, ackExp);
        load = 1'b0;
      end
      if (j == 2) checkOutput({tag, "/ackPulse"}, load_ack, 0);
      if (j >= 2) begin
        k   = (j - 2) / 4;
        pos = (j - 2) % 4;
        if (pos == 0) checkOutput($sformatf("%s/d%0d/deadAn", tag, k), an, 4'hf);
        if (pos == 1) begin
          if (sbQueue.size() == 0) checkOutput({tag, "/sbEmpty"}, 0, 1);
          else e = sbQueue.pop_front();
        end
        if (pos >= 1) checkOutput($sformatf("%s/d%0d/an", tag, k), an, e.an);
        if (pos == 2) checkOutput($sformatf("%s/d%0d/seg", tag, k), seg, e.seg);
      end
      if (j == 15) checkOutput({tag, "/noTick"}, frame_tick, 0);
      if (j == 16) checkOutput({tag, "/tick"}, frame_tick, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    value_i    = '0;
    load       = 1'b0;
    error      = 1'b0;
    blank      = 1'b0;
    lzb_en     = 1'b0;
    blink_mask = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst/an", an, 4'hf);
    checkOutput("rst/seg", seg, 7'h7f);
    checkOutput("rst/loadAck", load_ack, 0);
    checkOutput("rst/frameTick", frame_tick, 0);
    rst_n = 1'b1;

    $display("[TB] release with 0x1234 loaded");
    applyStimulus(16'h1234);
    waitFrameTick(n);
    checkOutput("firstTickCycles", n, 13);
    pushFrame(16'h1234, 1'b0, 1'b0, 1'b0, 4'h0);
    scanFrame("v1234", 1'b1);

    $display("[TB] leading-zero blanking 0x00A5");
    lzb_en = 1'b1;
    applyStimulus(16'h00A5);
    waitFrameTick(n);
    checkOutput("tickPeriod", n, 14);
    pushFrame(16'h00A5, 1'b1, 1'b0, 1'b0, 4'h0);
    scanFrame("lzbA5", 1'b1);

    $display("[TB] two loads in one frame");
    lzb_en = 1'b0;
    @(negedge clk);
    value_i = 16'h1111;
    load    = 1'b1;
    @(negedge clk);
    value_i = 16'h2222;
    @(negedge clk);
    load    = 1'b0;
    waitFrameTick(n);
    checkOutput("tickPeriod2", n, 13);
    pushFrame(16'h2222, 1'b0, 1'b0, 1'b0, 4'h0);
    scanFrame("last2222", 1'b1);
    pushFrame(16'h2222, 1'b0, 1'b0, 1'b0, 4'h0);
    scanFrame("hold2222", 1'b0);

    $display("[TB] load on the frame_tick cycle");
    value_i = 16'hC0DE;
    load    = 1'b1;
    pushFrame(16'hC0DE, 1'b0, 1'b0, 1'b0, 4'h0);
    scanFrame("onTick", 1'b1);

    $display("[TB] error and blank");
    error = 1'b1;
    pushFrame(16'hC0DE, 1'b0, 1'b1, 1'b0, 4'h0);
    scanFrame("err", 1'b0);
    blank = 1'b1;
    pushFrame(16'hC0DE, 1'b0, 1'b1, 1'b1, 4'h0);
    scanFrame("blankErr", 1'b0);
    error = 1'b0;
    blank = 1'b0;
    pushFrame(16'hC0DE, 1'b0, 1'b0, 1'b0, 4'h0);
    scanFrame("clearErr", 1'b0);

    $display("[TB] reset in the middle of digit 2");
    repeat (11) @(negedge clk);
    checkOutput("preRst/an", an, 4'b1011);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst/an", an, 4'hf);
    checkOutput("midRst/seg", seg, 7'h7f);
    checkOutput("midRst/frameTick", frame_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart/deadAn", an, 4'hf);
    @(negedge clk);
    checkOutput("restart/an", an, 4'b1110);
    checkOutput("restart/seg", seg, 7'h40);
    lzb_en     = 1'b1;
    blink_mask = 4'b0001;
    waitFrameTick(n);
    checkOutput("restartTick", n, 13);
    pushFrame(16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    scanFrame("lzbZero", 1'b0);

    $display("[TB] blink mask on digit 0");
    for (int f = 0; f < 4; f++) begin
      logic [3:0] darkExp;
      darkExp = (BLINK_ON && f < 2) ? 4'b0001 : 4'b0000;
      pushFrame(16'h0000, 1'b1, 1'b0, 1'b0, darkExp);
      scanFrame($sformatf("blink%0d", f), 1'b0);
    end

    checkOutput("sbDrained", sbQueue.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
